// File: rtl/bitplay.sv
// bitplay: replays run-length entries from a 512x32 RAM as a 1-bit waveform.
// Entry value L holds the current level for L+1 cycles. Entry 0 is always
// level 0, and each later entry toggles the level.
//
// Handshake: there is no valid/ready pair. A write lands on every cycle that
// writeEnable is high. start is accepted only in IDLE, only when entryCount is
// non-zero and only when stop is low. stop aborts playback from any state.
module bitplay (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [8:0]  writeIndex,
  input  logic [31:0] writeData,
  input  logic        start,
  input  logic        stop,
  input  logic [9:0]  entryCount,
  input  logic        loop,
  output logic        bitOut,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  // state_q is kept as a named register so checkers can bind to it.
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // remaining cycles in current segment
  logic [8:0]  seg_idx_q, seg_idx_d;  // entry index of the segment playing
  logic [9:0]  count_q, count_d;      // clamped entry count for this run
  logic        loop_q, loop_d;
  logic        bit_out_q, bit_out_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [512];
  logic [31:0] rd_data_q;
  logic [8:0]  rd_addr;
  logic        is_last;

  // Index of the entry that follows i, wrapping to 0 after the final entry.
  function automatic logic [8:0] next_of(input logic [8:0] i, input logic [9:0] n);
    logic [9:0] inc;
    inc = {1'b0, i} + 10'd1;
    return (inc == n) ? 9'd0 : inc[8:0];
  endfunction

  // Port A: bus writes. Port B: registered read that returns old data on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (writeEnable) mem[writeIndex] <= writeData;
    rd_data_q <= mem[rd_addr];
  end

  // Next-state logic. rd_data_q always holds the entry that will be loaded at
  // the next segment boundary. Port B re-reads that entry every cycle, so a
  // late write is still picked up whenever the timing allows it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seg_idx_d = seg_idx_q;
    count_d   = count_q;
    loop_d    = loop_q;
    bit_out_d = bit_out_q;
    is_last   = (({1'b0, seg_idx_q} + 10'd1) == count_q);

    case (state_q)
      ST_IDLE: begin
        bit_out_d = 1'b0;
        if (start && !stop && (entryCount != 10'd0)) begin
          state_d   = ST_FETCH;
          count_d   = (entryCount > 10'd512) ? 10'd512 : entryCount;
          loop_d    = loop;
          seg_idx_d = 9'd0;
        end
      end
      ST_FETCH: begin
        // Entry 0 was read on the start cycle; load it as segment 0.
        state_d   = ST_PLAY;
        cnt_d     = rd_data_q;
        bit_out_d = 1'b0;
        seg_idx_d = 9'd0;
      end
      ST_PLAY: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (!is_last) begin
          cnt_d     = rd_data_q;
          bit_out_d = ~bit_out_q;
          seg_idx_d = seg_idx_q + 9'd1;
        end else if (loop_q) begin
          // Wrap to entry 0. The level is forced low, so an odd count has no edge here.
          cnt_d     = rd_data_q;
          bit_out_d = 1'b0;
          seg_idx_d = 9'd0;
        end else begin
          state_d   = ST_IDLE;
          bit_out_d = 1'b0;
          seg_idx_d = 9'd0;
          cnt_d     = 32'd0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_out_d = 1'b0;
      end
    endcase

    if (stop) begin
      state_d   = ST_IDLE;
      bit_out_d = 1'b0;
      seg_idx_d = 9'd0;
      cnt_d     = 32'd0;
    end

    busy_d  = (state_d != ST_IDLE);
    rd_addr = (state_d == ST_PLAY) ? next_of(seg_idx_d, count_d) : 9'd0;
  end

  // State and output registers; reset aborts playback like stop does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      seg_idx_q <= 9'd0;
      count_q   <= 10'd0;
      loop_q    <= 1'b0;
      bit_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seg_idx_q <= seg_idx_d;
      count_q   <= count_d;
      loop_q    <= loop_d;
      bit_out_q <= bit_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bitOut = bit_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bitplay.sv
// Directed bench for bitplay: waveform timing, looping, abort paths,
// clamping and a run-length loopback capture.
module tb_bitplay;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [8:0]  writeIndex;
  logic [31:0] writeData;
  logic        start;
  logic        stop;
  logic [9:0]  entryCount;
  logic        loop;
  logic        bitOut;
  logic        busy;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];

  bitplay dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeIndex  (writeIndex),
    .writeData   (writeData),
    .start       (start),
    .stop        (stop),
    .entryCount  (entryCount),
    .loop        (loop),
    .bitOut      (bitOut),
    .busy        (busy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks.
  task automatic bus_write(input logic [8:0] idx, input logic [31:0] data);
    writeEnable = 1'b1;
    writeIndex  = idx;
    writeData   = data;
    tick();
    writeEnable = 1'b0;
  endtask

  // Pulses start for one cycle. On return, the bench observes cycle S+1.
  task automatic pulse_start(input logic [9:0] cnt, input logic lp);
    entryCount = cnt;
    loop       = lp;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advances n cycles. Bit i of bits/busys is the expected value in the i-th cycle.
  task automatic expect_seq(input string tag, input logic [15:0] bits,
                            input logic [15:0] busys, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s bit[%0d]", tag, i), {31'd0, bitOut}, {31'd0, bits[i]});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, {31'd0, busys[i]});
    end
  endtask

  task automatic write_301();
    bus_write(9'd0, 32'd3);
    bus_write(9'd1, 32'd0);
    bus_write(9'd2, 32'd1);
  endtask

  initial begin
    int busy_cycles;
    int high_cycles;
    int run;
    logic cur;
    logic [31:0] len;

    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    writeEnable = 1'b0;
    writeIndex  = '0;
    writeData   = '0;
    start       = 1'b0;
    stop        = 1'b0;
    entryCount  = '0;
    loop        = 1'b0;
    repeat (3) tick();
    check("reset bitOut", {31'd0, bitOut}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Entries {3,0,1}: low S+2..S+5, high S+6, low S+7..S+8, idle S+9.
    write_301();
    pulse_start(10'd3, 1'b0);
    check("t1 busy S+1", {31'd0, busy}, 32'd1);
    expect_seq("t1", 16'b0000_0000_0001_0000, 16'b0000_0000_0111_1111, 8);

    // All-zero entries: toggle each cycle, busy for exactly S+1..S+5.
    for (int i = 0; i < 4; i++) bus_write(i[8:0], 32'd0);
    pulse_start(10'd4, 1'b0);
    check("t2 busy S+1", {31'd0, busy}, 32'd1);
    expect_seq("t2", 16'b0000_0000_0000_1010, 16'b0000_0000_0000_1111, 5);

    // Loop {1,1}: period-4 square wave 0,0,1,1 with no gap at the wrap.
    bus_write(9'd0, 32'd1);
    bus_write(9'd1, 32'd1);
    pulse_start(10'd2, 1'b1);
    expect_seq("loop", 16'b0000_0000_1100_1100, 16'h00FF, 8);
    // A start while busy must not disturb the pattern.
    pulse_start(10'd1, 1'b0);
    check("busy start bit", {31'd0, bitOut}, 32'd0);
    check("busy start busy", {31'd0, busy}, 32'd1);
    expect_seq("loop cont", 16'b0000_0000_0000_0010, 16'h0003, 2);
    // bitOut is high now. A stop must drop both outputs on the next cycle.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop bit", {31'd0, bitOut}, 32'd0);
    check("stop busy", {31'd0, busy}, 32'd0);

    // A start with entryCount=0 is ignored.
    pulse_start(10'd0, 1'b0);
    check("cnt0 busy", {31'd0, busy}, 32'd0);
    tick();
    check("cnt0 busy+1", {31'd0, busy}, 32'd0);

    // When start and stop arrive together in IDLE, stop wins.
    stop = 1'b1;
    pulse_start(10'd2, 1'b0);
    stop = 1'b0;
    check("start+stop busy", {31'd0, busy}, 32'd0);
    tick();
    check("start+stop busy+1", {31'd0, busy}, 32'd0);

    // entryCount=600 is clamped to 512 zero-length entries: 1 fetch + 512 play cycles.
    for (int i = 0; i < 512; i++) bus_write(i[8:0], 32'd0);
    pulse_start(10'd600, 1'b0);
    busy_cycles = 0;
    high_cycles = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      busy_cycles++;
      if (bitOut) high_cycles++;
      tick();
    end
    check("clamp busy cycles", busy_cycles, 32'd513);
    check("clamp high cycles", high_cycles, 32'd256);

    // A reset in mid-segment aborts playback. Memory contents survive it.
    write_301();
    pulse_start(10'd3, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst bit", {31'd0, bitOut}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    tick();
    pulse_start(10'd3, 1'b0);
    check("rerun busy S+1", {31'd0, busy}, 32'd1);
    expect_seq("rerun", 16'b0000_0000_0001_0000, 16'b0000_0000_0111_1111, 8);

    // Loopback: capture run lengths from bitOut and compare them with the written entries.
    for (int i = 0; i < 20; i++) begin
      len = 32'($urandom_range(0, 50));
      exp_q.push_back(len);
      bus_write(i[8:0], len);
    end
    pulse_start(10'd20, 1'b0);
    tick();
    cur = bitOut;
    run = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy || bitOut != cur) begin
        log_q.push_back(32'(run - 1));
        cur = bitOut;
        run = 1;
      end else begin
        run++;
      end
      if (!busy) break;
    end
    check("loopback entries", log_q.size(), 32'd20);
    for (int i = 1; i < 20; i++) begin
      if (i < log_q.size())
        check($sformatf("loopback entry %0d", i), log_q[i], exp_q[i]);
      else
        check($sformatf("loopback entry %0d missing", i), 32'hDEAD_BEEF, exp_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitplay.md
# bitplay

RLE waveform generator on the GPU bus: the playback counterpart of the bit logger. The bus fills a 512×32 memory with run lengths in the logger's format. A start command then replays those run lengths as a 1-bit output waveform. Any capture taken by the logger can be replayed cycle-exactly into a DUT pin or back into a logger for loopback checks.

## Interface
Parameters: none (depth fixed at 512 entries, 9-bit index; data 32 bits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- writeEnable  in  1  bus write strobe; one entry written per asserted cycle
- writeIndex  in  9  entry address for the write
- writeData  in  32  run length to store
- start  in  1  single-cycle pulse; begins playback
- stop  in  1  single-cycle pulse; aborts playback
- entryCount  in  10  number of entries to play; sampled on the accepted start
- loop  in  1  repeat the sequence; sampled on the accepted start
- bitOut  out  1  replayed waveform; registered
- busy  out  1  high while playback is active; registered

## Operation
- Memory:
  - One dual-port block RAM. Port A is bus write only; port B is the playback read, with 1-cycle read latency.
  - Contents are not cleared by reset.
- Entry format, identical to the logger: entry value L means the level is held for L+1 cycles.
  - Entry 0 is always a level-0 run. Each later entry toggles the level.
  - A waveform that starts at 1 therefore begins with entry 0 = 0, which produces a 1-cycle low glitch. This is accepted behaviour.
- FSM states:
  - IDLE: bitOut=0, busy=0.
  - FETCH: 1 cycle; entry 0 is read.
  - PLAY: segments are output back-to-back.
- IDLE -> FETCH on start when entryCount != 0.
  - start with entryCount=0 is ignored.
  - entryCount > 512 is clamped to 512.
- FETCH -> PLAY unconditionally.
- In PLAY:
  - A 32-bit down-counter loads L and bitOut takes the segment level.
  - When the counter reaches 0, the next segment starts on the following cycle.
  - The next entry is prefetched during the current segment, so L=0 segments play back-to-back without gaps.
- Final segment end:
  - loop=0 -> IDLE; bitOut=0 and busy=0 on the next cycle.
  - loop=1 -> entry 0 plays on the next cycle, with no gap and level forced to 0. With an odd entryCount there is no edge at the wrap.
- stop, or start while busy:
  - stop forces IDLE on the next cycle; bitOut=0, busy=0.
  - start while busy is ignored.
  - stop and start in the same cycle: stop wins.
- Writes during playback are allowed.
  - A write takes effect for an entry if it lands at least 2 cycles before that entry's segment begins.
  - Otherwise the old value plays. This is not an error.
- Simultaneous bus write and port-B read of the same address: port B returns the old data.

## Timing
- Reset value of every output: bitOut=0, busy=0. FSM goes to IDLE, counters and index go to 0.
- Reset mid-playback aborts exactly like stop.
- Start latency:
  - start accepted in cycle S.
  - busy=1 from S+1.
  - bitOut shows segment 0 (level 0) from S+2.
- Segment k with length Lk occupies exactly Lk+1 consecutive cycles. Edges fall exactly at the segment boundaries.
- Total duration for loop=0: sum(Li+1) cycles. busy falls in the first cycle after the last segment.
- Bus writes complete in 1 cycle and there is no wait output. Back-to-back writes are supported.
- Length arithmetic is unsigned 32-bit. L=0xFFFFFFFF gives 2^32 cycles with no overflow, since the counter counts down.

## Test plan
- Write {3,0,1}, entryCount=3, loop=0, start at S. Required:
  - bitOut=0 over S+2..S+5
  - bitOut=1 at S+6
  - bitOut=0 over S+7..S+8
  - busy=0 and bitOut=0 at S+9
- All-zero entries, entryCount=4: bitOut toggles every cycle 0,1,0,1, then returns to 0. busy is high for exactly 5 cycles (S+1..S+5).
- Loop: {1,1}, entryCount=2, loop=1 gives period-4 square wave 0,0,1,1 repeating with no gap at the wrap. stop pulse -> bitOut=0 and busy=0 on the next cycle.
- Boundaries:
  - entryCount=0 start -> busy stays 0.
  - entryCount=600 -> plays exactly 512 entries.
  - start while busy -> ignored.
  - reset mid-segment -> bitOut=0, busy=0 next cycle; memory still holds the written data on restart.
- Loopback: feed bitOut into a bit logger, play 20 random lengths (0..50). The logger's entries 1..19 must equal the written entries 1..19.
